zap_mem_fill_ctrl: RTL

ZAP_MEM_FILL_CTRL -- requirements
Module: zap_mem_fill_ctrl

---
 rtl/zap_mem_fill_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/zap_mem_fill_ctrl.sv
// Line-fill controller: bursts one cache line over Wishbone (incrementing
// CTI) and writes each returned beat into an invalidatable RAM one cycle later.
module zap_mem_fill_ctrl #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req,
  input  logic [31:0]              i_req_addr,
  input  logic                     i_inv,
  output logic                     o_busy,
  output logic                     o_req_ack,
  output logic                     o_err,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic [31:0]              o_wb_adr,
  output logic [2:0]               o_wb_cti,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [WIDTH-1:0]         i_wb_dat,
  output logic                     o_ram_wen,
  output logic                     o_ram_clken,
  output logic [$clog2(DEPTH)-1:0] o_ram_waddr,
  output logic [WIDTH-1:0]         o_ram_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LB = $clog2(LINE_WORDS);
  localparam logic [31:0]   LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [LB-1:0] LAST_BEAT = LB'(LINE_WORDS - 1);
  localparam logic [2:0]    CTI_INCR  = 3'b010;
  localparam logic [2:0]    CTI_END   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is kept as a plain named register so checkers can bind to it.
  state_t           state;
  logic [31:0]      base_q;
  logic [LB-1:0]    beat;
  logic [LB-1:0]    beat_nxt;
  logic             poison;
  logic             wen_q;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wdata_q;

  assign beat_nxt = beat + LB'(1);

  // Bus handshake: a beat is presented while stb=1 and is consumed on the
  // cycle i_wb_ack (or i_wb_err) is high; adr/cti/stb hold until then.
  // An invalidate in the current cycle always wins over a pending write.
  assign o_ram_wen   = wen_q & ~i_inv;
  assign o_ram_clken = wen_q & ~i_inv;
  assign o_ram_waddr = waddr_q;
  assign o_ram_wdata = wdata_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      base_q    <= '0;
      beat      <= '0;
      poison    <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      o_busy    <= 1'b0;
      o_req_ack <= 1'b0;
      o_err     <= 1'b0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_adr  <= '0;
      o_wb_cti  <= '0;
    end else begin
      wen_q     <= 1'b0;
      o_req_ack <= 1'b0;
      o_err     <= 1'b0;

      case (state)
        IDLE: begin
          if (i_req && !i_inv) begin
            base_q   <= i_req_addr & ~LINE_MASK;
            beat     <= '0;
            poison   <= 1'b0;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_adr <= i_req_addr & ~LINE_MASK;
            o_wb_cti <= CTI_INCR;
            o_busy   <= 1'b1;
            state    <= FILL;
          end
        end

        FILL: begin
          if (i_inv) begin
            poison <= 1'b1;
          end
          if (i_wb_err) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_cti <= '0;
            o_err    <= 1'b1;
            o_busy   <= 1'b0;
            beat     <= '0;
            state    <= IDLE;
          end else if (i_wb_ack) begin
            // A beat returned while poisoned (or during an invalidate) is dropped.
            wen_q   <= ~poison & ~i_inv;
            waddr_q <= o_wb_adr[AW+1:2];
            wdata_q <= i_wb_dat;
            if (beat == LAST_BEAT) begin
              o_wb_cyc  <= 1'b0;
              o_wb_stb  <= 1'b0;
              o_wb_cti  <= '0;
              o_req_ack <= 1'b1;
              beat      <= '0;
              state     <= DONE;
            end else begin
              beat     <= beat_nxt;
              o_wb_adr <= base_q | (32'(beat_nxt) << 2);
              o_wb_cti <= (beat_nxt == LAST_BEAT) ? CTI_END : CTI_INCR;
            end
          end
        end

        DONE: begin
          if (i_inv) begin
            poison <= 1'b1;
          end
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
